seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, least-significant chunk first. It replaces fixed-width single-cycle ripple adders in the multiplier datapaths where area matters more than latency. It also reports carry-out and signed overflow, and uses a start/busy/done handshake.

---
 rtl/seq_chunk_adder_pkg.sv | 42 ++++
 rtl/seq_chunk_adder_add_chunk.sv | 27 ++
 rtl/seq_chunk_adder.sv | 121 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: default geometry,
// counter sizing, FSM encoding and the half/full-adder cells.
package seq_chunk_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Counter width for n chunks, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  localparam int NUM_CHUNKS = DEF_WIDTH / DEF_CHUNK;
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-adder cell from two half adders: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = ha(x, y);
    h2 = ha(h1[0], c);
    return {h1[1] | h2[1], h2[0]};
  endfunction

endpackage

// File: rtl/seq_chunk_adder_add_chunk.sv
// CHUNK-bit combinational ripple adder built from the package fa cell.
module add_chunk
  import seq_chunk_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      {c[i+1], s[i]} = fa(x[i], y[i], c[i]);
    end
    co = c[CHUNK];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: adds a + b + cin CHUNK bits per clock, LSB chunk first,
// with start/busy/done handshake, carry-out and signed overflow.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = cnt_width(NCH);
  localparam logic [CW-1:0] LAST_K = CW'(NCH - 1);

  if (((WIDTH % CHUNK) != 0) || (CHUNK < 1) || (CHUNK > WIDTH)) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_r;
  logic [CW-1:0]    k_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic [WIDTH-1:0] res_next_s;
  logic             a_msb_s;
  logic             b_msb_s;
  logic             ovf_next_s;

  // Operand shift registers present the current chunk in their low bits.
  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .x  (a_sh_r[CHUNK-1:0]),
    .y  (b_sh_r[CHUNK-1:0]),
    .ci (carry_r),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Merge the current chunk into the result; on the last chunk the shifted
  // operands hold their original MSBs in bit CHUNK-1, which feeds overflow.
  always_comb begin
    res_next_s = res_r;
    res_next_s[int'(k_r) * CHUNK +: CHUNK] = chunk_s;
    a_msb_s    = a_sh_r[CHUNK-1];
    b_msb_s    = b_sh_r[CHUNK-1];
    ovf_next_s = (a_msb_s == b_msb_s) && (res_next_s[WIDTH-1] != a_msb_s);
  end

  // Control FSM, chunk counter, operand/result registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= '0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            res_r   <= '0;
            k_r     <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> CHUNK;
          b_sh_r  <= b_sh_r >> CHUNK;
          carry_r <= chunk_co;
          res_r   <= res_next_s;
          if (k_r == LAST_K) begin
            k_r     <= '0;
            sum     <= res_next_s;
            cout    <= chunk_co;
            ovf     <= ovf_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            k_r     <= k_r + CW'(1);
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          k_r     <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: three instances (CHUNK 8, 32, 1),
// an arithmetic reference model checked every cycle, plus directed cases.
module tb_seq_chunk_adder;

  logic            clk;
  logic            rst_n;
  logic [2:0]      start_v;
  logic [2:0][31:0] a_v;
  logic [2:0][31:0] b_v;
  logic [2:0]      cin_v;
  logic [2:0]      busy_v;
  logic [2:0]      done_v;
  logic [2:0][31:0] sum_v;
  logic [2:0]      cout_v;
  logic [2:0]      ovf_v;

  int n_pass  = 0;
  int n_total = 0;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
    .cout(cout_v[0]), .ovf(ovf_v[0]));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
    .cout(cout_v[1]), .ovf(ovf_v[1]));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
    .cout(cout_v[2]), .ovf(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency in cycles of each instance (32 / CHUNK).
  function automatic int lat_of(input int i);
    if (i == 0) return 4;
    else if (i == 1) return 1;
    else return 32;
  endfunction

  // Reference result {ovf, cout, sum} from plain arithmetic.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + {32'd0, c};
    return {(x[31] == y[31]) && (t[31] != x[31]), t[32], t[31:0]};
  endfunction

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted start yields its result N cycles later.
  bit          m_busy [3];
  bit          m_done [3];
  int          m_rem  [3];
  logic [33:0] m_pend [3];
  logic [33:0] m_out  [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_rem[i]  <= 0;
        m_pend[i] <= '0;
        m_out[i]  <= '0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_rem[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_out[i]  <= m_pend[i];
          end
          m_rem[i] <= m_rem[i] - 1;
        end else if (start_v[i]) begin
          m_busy[i] <= 1'b1;
          m_rem[i]  <= lat_of(i);
          m_pend[i] <= ref_add(a_v[i], b_v[i], cin_v[i]);
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("cyc_busy", i, 64'(busy_v[i]), 64'(m_busy[i]));
      chk("cyc_done", i, 64'(done_v[i]), 64'(m_done[i]));
      chk("cyc_result", i, 64'({ovf_v[i], cout_v[i], sum_v[i]}), 64'(m_out[i]));
    end
  end

  task automatic do_start(input int i, input logic [31:0] x, input logic [31:0] y, input logic c);
    a_v[i]     = x;
    b_v[i]     = y;
    cin_v[i]   = c;
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
  endtask

  // Wait (bounded) for done; check latency, busy length and result.
  task automatic wait_done(input int i, input logic [33:0] exp, input int exp_lat, input string nm);
    int cyc;
    int nbusy;
    bit got;
    cyc = 0; nbusy = 0; got = 1'b0;
    while ((cyc < 200) && !got) begin
      @(negedge clk);
      cyc++;
      if (done_v[i]) got = 1'b1;
      else if (busy_v[i]) nbusy++;
    end
    chk({nm, "_done_seen"}, i, 64'(got), 64'd1);
    if (got) begin
      if (exp_lat > 0) begin
        chk({nm, "_latency"}, i, 64'(cyc - 1), 64'(exp_lat));
        chk({nm, "_busy_len"}, i, 64'(nbusy), 64'(exp_lat));
      end
      chk({nm, "_result"}, i, 64'({ovf_v[i], cout_v[i], sum_v[i]}), 64'(exp));
    end
  endtask

  initial begin
    int ndone;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    rst_n   = 1'b0;
    start_v = '0;
    a_v     = '0;
    b_v     = '0;
    cin_v   = '0;

    // Pin the reference model with hand-computed values.
    chk("ref_small", 0, 64'(ref_add(32'h1, 32'h2, 1'b0)), 64'h0_00000003);
    chk("ref_wrap", 0, 64'(ref_add(32'hFFFFFFFF, 32'h1, 1'b0)), 64'h1_00000000);
    chk("ref_pos_ovf", 0, 64'(ref_add(32'h7FFFFFFF, 32'h1, 1'b0)), 64'h2_80000000);
    chk("ref_neg_ovf", 0, 64'(ref_add(32'h80000000, 32'h80000000, 1'b0)), 64'h3_00000000);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 0, 64'(busy_v), 64'd0);
    chk("reset_done", 0, 64'(done_v), 64'd0);
    chk("reset_sum", 0, 64'(sum_v[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_start(0, 32'h00000001, 32'h00000002, 1'b0);
    wait_done(0, 34'h0_00000003, 4, "small");
    @(posedge clk); #1;
    do_start(0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done(0, 34'h1_00000000, 4, "ripple");
    @(posedge clk); #1;
    do_start(0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    wait_done(0, 34'h1_00000000, 4, "cin_ripple");
    @(posedge clk); #1;
    do_start(0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done(0, 34'h2_80000000, 4, "pos_ovf");
    // Start in the done cycle: accepted back-to-back.
    do_start(0, 32'h80000000, 32'h80000000, 1'b0);
    wait_done(0, 34'h3_00000000, 4, "b2b_neg_ovf");

    // Ignored start while busy.
    @(posedge clk); #1;
    do_start(0, 32'd5, 32'd6, 1'b0);
    @(posedge clk); #1;
    do_start(0, 32'd100, 32'd200, 1'b0);
    wait_done(0, 34'd11, -1, "ignored_start");
    @(negedge clk);
    chk("after_done_busy", 0, 64'(busy_v[0]), 64'd0);
    chk("after_done_sum", 0, 64'(sum_v[0]), 64'd11);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("no_second_done", 0, 64'(ndone), 64'd0);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    do_start(0, 32'h12345678, 32'h11111111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 0, 64'(busy_v[0]), 64'd0);
    chk("midrst_done", 0, 64'(done_v[0]), 64'd0);
    chk("midrst_result", 0, 64'({ovf_v[0], cout_v[0], sum_v[0]}), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("midrst_no_done", 0, 64'(ndone), 64'd0);
    @(posedge clk); #1;
    do_start(0, 32'd1, 32'd1, 1'b0);
    wait_done(0, 34'd2, 4, "after_reset");

    // Configuration sweep: CHUNK=32 and CHUNK=1, directed then random.
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      do_start(i, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      wait_done(i, 34'h1_00000000, lat_of(i), "sweep_wrap");
      do_start(i, 32'h7FFFFFFF, 32'h00000001, 1'b0);
      wait_done(i, 34'h2_80000000, lat_of(i), "sweep_ovf");
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        do_start(i, ra, rb, rc);
        wait_done(i, ref_add(ra, rb, rc), lat_of(i), "sweep_rand");
      end
    end

    @(posedge clk); #1;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
